// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and default parameters for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  // Types
  localparam int REG_ID_W = 5;
  localparam int OP_W     = 32;
  localparam int NUM_REGS = 1 << REG_ID_W;

  typedef logic [REG_ID_W-1:0] reg_id_t;
  typedef logic [OP_W-1:0]     op_t;

  // Parameters
  localparam int STARVE_LIMIT_DEFAULT = 3;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Valid/ready result channel from one producer into the write-back arbiter.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic    valid;
  logic    ready;
  reg_id_t id;
  op_t     data;

  // Producer side: offers a result and waits for ready.
  modport master (output valid, output id, output data, input ready);
  // Arbiter side: accepts a result when it raises ready.
  modport slave  (input valid, input id, input data, output ready);

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register busy bits tracking writes that have been issued but not yet
// written back, plus a sticky flag for double reservations.
module regfile_wb_arbiter_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    rsv_valid,
  input  reg_id_t rsv_id,
  input  logic    clr_valid,
  input  reg_id_t clr_id,
  input  reg_id_t chk1_id,
  input  reg_id_t chk2_id,
  output logic    chk1_busy,
  output logic    chk2_busy,
  output logic    rsv_conflict
);

  // Register 0 never has a flop; its busy bit is tied low.
  logic [NUM_REGS-1:1] busy_q, busy_d;
  logic [NUM_REGS-1:1] set_hit, clr_hit;
  logic [NUM_REGS-1:0] busy_vec;
  logic                conflict_q, conflict_d;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
      assign set_hit[gi] = rsv_valid && (rsv_id == reg_id_t'(gi));
      assign clr_hit[gi] = clr_valid && (clr_id == reg_id_t'(gi));
    end
  endgenerate

  // Set beats clear: a same-cycle reservation belongs to a younger instruction.
  always_comb begin
    busy_d     = (busy_q & ~clr_hit) | set_hit;
    conflict_d = conflict_q | (|(set_hit & busy_q & ~clr_hit));
  end

  // Busy vector and sticky conflict flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy_vec     = {busy_q, 1'b0};
  assign chk1_busy    = busy_vec[chk1_id];
  assign chk2_busy    = busy_vec[chk2_id];
  assign rsv_conflict = conflict_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: ALU has
// priority over the MDU, with an age counter that stops the MDU starving.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  alu,
  regfile_wb_arbiter_if.slave  mdu,
  input  logic                 rsv_valid,
  input  reg_id_t              rsv_id,
  input  reg_id_t              chk1_id,
  input  reg_id_t              chk2_id,
  output logic                 chk1_busy,
  output logic                 chk2_busy,
  output logic                 wr_en,
  output reg_id_t              wr_id,
  output op_t                  wr_data,
  output logic                 rsv_conflict
);

  localparam int                AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0]  AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age_q, age_d;
  logic             wr_en_q, wr_en_d;
  reg_id_t          wr_id_q, wr_id_d;
  op_t              wr_data_q, wr_data_d;

  logic             mdu_aged;
  logic             grant_alu, grant_mdu, win_valid;
  reg_id_t          win_id;
  op_t              win_data;

  assign mdu_aged  = (age_q == AGE_MAX);
  assign grant_alu = alu.valid && !(mdu.valid && mdu_aged);
  assign grant_mdu = mdu.valid && (!alu.valid || mdu_aged);
  assign win_valid = grant_alu || grant_mdu;
  assign win_id    = grant_mdu ? mdu.id   : alu.id;
  assign win_data  = grant_mdu ? mdu.data : alu.data;

  assign alu.ready = grant_alu;
  assign mdu.ready = grant_mdu;

  // Age counts consecutive MDU denials; any grant or idle MDU restarts it.
  always_comb begin
    age_d = age_q;
    if (!mdu.valid || grant_mdu) begin
      age_d = '0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  // Write stage: register the winner; id 0 completes but never writes.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_id_d   = wr_id_q;
    wr_data_d = wr_data_q;
    if (win_valid) begin
      wr_en_d   = (win_id != '0);
      wr_id_d   = win_id;
      wr_data_d = win_data;
    end
  end

  // Age counter and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_id_q   <= '0;
      wr_data_q <= '0;
    end else begin
      age_q     <= age_d;
      wr_en_q   <= wr_en_d;
      wr_id_q   <= wr_id_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_id   = wr_id_q;
  assign wr_data = wr_data_q;

  regfile_wb_arbiter_scoreboard u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .rsv_valid    (rsv_valid),
    .rsv_id       (rsv_id),
    .clr_valid    (win_valid),
    .clr_id       (win_id),
    .chk1_id      (chk1_id),
    .chk2_id      (chk2_id),
    .chk1_busy    (chk1_busy),
    .chk2_busy    (chk2_busy),
    .rsv_conflict (rsv_conflict)
  );

endmodule
